// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: pointer/count/flag controller for an external
// dual-port RAM FIFO, with sticky errors and synchronous flush.
module fifo_ctrl_param #(
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_C  = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_C  = (AW+1)'(AE_LEVEL);

  // Flags decode from the registered count only.
  always_comb begin
    full         = (count == C_MAX);
    empty        = (count == '0);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
  end

  // RAM strobes gated by current flags; silent during reset.
  always_comb begin
    wr_en = rst & push & ~full & ~clear;
    rd_en = rst & pop & ~empty & ~clear;
  end

  // Write pointer with explicit wrap at DEPTH-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr <= '0;
    end else if (clear) begin
      wr_addr <= '0;
    end else if (wr_en) begin
      wr_addr <= (wr_addr == LAST) ? '0 : wr_addr + P_ONE;
    end
  end

  // Read pointer with explicit wrap at DEPTH-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr <= '0;
    end else if (clear) begin
      rd_addr <= '0;
    end else if (rd_en) begin
      rd_addr <= (rd_addr == LAST) ? '0 : rd_addr + P_ONE;
    end
  end

  // Occupancy: net of accepted writes and reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky errors for rejected requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full)
        overflow <= 1'b1;
      if (pop && empty)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// tb_fifo_ctrl_param: two FIFO controllers (DEPTH 4 and 5) on shared
// stimulus, compared against a transaction-count reference model.
module tb_fifo_ctrl_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic clear = 1'b0;

  logic       we4, re4, f4, e4, af4, ae4, ov4, un4;
  logic [1:0] wa4, ra4;
  logic [2:0] c4;
  logic       we5, re5, f5, e5, af5, ae5, ov5, un5;
  logic [2:0] wa5, ra5;
  logic [3:0] c5;

  int checks = 0;
  int errors = 0;

  int dep[2] = '{4, 5};
  int afl[2] = '{3, 3};
  int ael[2] = '{1, 2};
  int wtot[2] = '{0, 0};
  int rtot[2] = '{0, 0};
  bit ovf[2] = '{0, 0};
  bit unf[2] = '{0, 0};

  always #5 clk = ~clk;

  fifo_ctrl_param #(
    .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)
  ) u4 (
    .clk(clk), .rst(rst), .push(push),
    .pop(pop), .clear(clear),
    .wr_en(we4), .rd_en(re4),
    .wr_addr(wa4), .rd_addr(ra4),
    .count(c4), .full(f4), .empty(e4),
    .almost_full(af4), .almost_empty(ae4),
    .overflow(ov4), .underflow(un4)
  );

  fifo_ctrl_param #(
    .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2)
  ) u5 (
    .clk(clk), .rst(rst), .push(push),
    .pop(pop), .clear(clear),
    .wr_en(we5), .rd_en(re5),
    .wr_addr(wa5), .rd_addr(ra5),
    .count(c5), .full(f5), .empty(e5),
    .almost_full(af5), .almost_empty(ae5),
    .overflow(ov5), .underflow(un5)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input int k);
    int d, c;
    bit we, re;
    logic [31:0] o[11];
    string p;
    d = dep[k];
    c = wtot[k] - rtot[k];
    we = rst && push && (c < d) && !clear;
    re = rst && pop && (c > 0) && !clear;
    p = $sformatf("d%0d", d);
    if (k == 0) begin
      o = '{32'(we4), 32'(re4), 32'(wa4),
            32'(ra4), 32'(c4), 32'(f4),
            32'(e4), 32'(af4), 32'(ae4),
            32'(ov4), 32'(un4)};
    end else begin
      o = '{32'(we5), 32'(re5), 32'(wa5),
            32'(ra5), 32'(c5), 32'(f5),
            32'(e5), 32'(af5), 32'(ae5),
            32'(ov5), 32'(un5)};
    end
    check({p, ".wr_en"}, o[0], 32'(we));
    check({p, ".rd_en"}, o[1], 32'(re));
    check({p, ".wr_addr"}, o[2], wtot[k] % d);
    check({p, ".rd_addr"}, o[3], rtot[k] % d);
    check({p, ".count"}, o[4], c);
    check({p, ".full"}, o[5], 32'(c == d));
    check({p, ".empty"}, o[6], 32'(c == 0));
    check({p, ".a_full"}, o[7], 32'(c >= afl[k]));
    check({p, ".a_empty"}, o[8], 32'(c <= ael[k]));
    check({p, ".overflow"}, o[9], 32'(ovf[k]));
    check({p, ".underflow"}, o[10], 32'(unf[k]));
  endtask

  task automatic model_reset(input int k);
    wtot[k] = 0;
    rtot[k] = 0;
    ovf[k] = 1'b0;
    unf[k] = 1'b0;
  endtask

  task automatic model_edge(input int k);
    int c;
    c = wtot[k] - rtot[k];
    if (!rst || clear) begin
      model_reset(k);
    end else begin
      if (push && c < dep[k]) wtot[k]++;
      if (pop && c > 0) rtot[k]++;
      if (push && c == dep[k]) ovf[k] = 1'b1;
      if (pop && c == 0) unf[k] = 1'b1;
    end
  endtask

  task automatic step(input bit p, input bit q, input bit c);
    @(negedge clk);
    push = p;
    pop = q;
    clear = c;
    #1;
    for (int k = 0; k < 2; k++) check_all(k);
    for (int k = 0; k < 2; k++) model_edge(k);
  endtask

  task automatic async_reset();
    @(negedge clk);
    push = 1'b1;
    pop = 1'b0;
    clear = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) model_reset(k);
    for (int k = 0; k < 2; k++) check_all(k);
    @(negedge clk);
    rst = 1'b1;
    push = 1'b0;
  endtask

  initial begin
    int pp;
    int qq;
    #3;
    for (int k = 0; k < 2; k++) check_all(k);
    @(negedge clk);
    rst = 1'b1;

    repeat (5) step(1, 0, 0);
    repeat (5) step(0, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    step(0, 0, 1);
    repeat (7) begin
      step(1, 0, 0);
      step(0, 1, 0);
    end
    step(1, 0, 0);
    step(1, 0, 0);
    async_reset();
    step(1, 0, 0);
    step(0, 0, 0);

    for (int ph = 0; ph < 30; ph++) begin
      pp = (ph % 2 == 0) ? 75 : 25;
      qq = 100 - pp;
      repeat (60) begin
        if ($urandom_range(0, 199) == 0) begin
          async_reset();
        end else begin
          step($urandom_range(0, 99) < pp,
               $urandom_range(0, 99) < qq,
               $urandom_range(0, 49) == 0);
        end
      end
    end
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
- Parametrised FIFO controller; next generation of the processor FIFO push/pop gating logic.
- Owns read/write pointers, occupancy count, full/empty and programmable almost-full/almost-empty flags, sticky overflow/underflow errors, and synchronous flush.
- Drives an external dual-port RAM (write address/enable, read address/enable); data path is outside this block.
- Sits between the processor-side push/pop requesters and the FIFO storage.

Parameters:
- DEPTH, 8, number of entries; any integer >= 2 (power of two not required).
- AW, $clog2(DEPTH), address width of wr_addr/rd_addr.
- AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- push  input  1  write request; level, one entry per cycle while high.
- pop  input  1  read request; level, one entry per cycle while high.
- clear  input  1  synchronous flush; highest priority after reset.
- wr_en  output  1  RAM write strobe (combinational).
- rd_en  output  1  RAM read strobe (combinational).
- wr_addr  output  AW  RAM write address (registered pointer).
- rd_addr  output  AW  RAM read address (registered pointer).
- count  output  AW+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- overflow  output  1  sticky; push while full and not accepted.
- underflow  output  1  sticky; pop while empty and not accepted.

Behaviour:
- Reset (rst low, async): wr_addr = 0, rd_addr = 0, count = 0, overflow = 0, underflow = 0. Flags follow: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0 ? 1 : 0), i.e. 0 for legal settings. wr_en = rd_en = 0 while rst is low.
- Flags are decoded from registered count only; no combinational path from push/pop to any flag.
- Write acceptance: wr_en = push & ~full & ~clear.
- Read acceptance: rd_en = pop & ~empty & ~clear.
- Both strobes use the flag values from the current cycle (pre-update).
- Accepted write: the RAM writes at wr_addr this edge; then wr_addr <= (wr_addr == DEPTH-1) ? 0 : wr_addr + 1.
- Accepted read: rd_addr is valid on the RAM this cycle; then rd_addr advances with the same explicit wrap at DEPTH-1.
- Read data latency is defined by the RAM, not by this block.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both or neither are accepted.
- Simultaneous push and pop:
  - Empty: write accepted, read rejected, underflow set; count becomes 1.
  - Full: read accepted, write rejected, overflow set; count becomes DEPTH-1.
  - Otherwise: both accepted; count unchanged; both pointers advance.
- Errors:
  - overflow <= 1 on push & full & ~clear.
  - underflow <= 1 on pop & empty & ~clear.
  - Both stay set until clear or reset. Rejected requests never move pointers or count.
- clear (sync): next edge sets pointers, count, overflow and underflow to 0; push/pop in the same cycle are ignored.
- Reset mid-operation: immediate return to reset values regardless of in-flight request; no write strobe is generated while rst is low.
- No state machine beyond the pointer/count registers. The legacy IDLE/PUSH/POP sequencing is not used; full throughput of one push and one pop per cycle is required.

Test Plan (DEPTH=4, AF_LEVEL=3, AE_LEVEL=1 unless stated):
1. Reset, then 4 push cycles:
   - wr_addr 0,1,2,3 with wr_en=1.
   - count 1,2,3,4.
   - almost_empty drops at count 2; almost_full rises at count 3; full at count 4.
   - 5th push: wr_en=0, overflow=1, count stays 4.
2. From full, 4 pop cycles:
   - rd_addr 0,1,2,3; count to 0; empty=1.
   - Next pop: rd_en=0, underflow=1, rd_addr stays 0.
3. Wrap-around with DEPTH=5:
   - 7 pushes interleaved with 7 pops, keeping count <= 2.
   - Both pointers sequence 0,1,2,3,4,0,1; count never exceeds 2.
4. Simultaneous push+pop:
   - When empty: wr_en=1, rd_en=0, count becomes 1, underflow=1.
   - At count=2: both strobes high, count stays 2, both pointers +1.
   - When full: rd_en=1, wr_en=0, count becomes 3, overflow=1.
5. clear:
   - At count=3 with overflow=1 and push held high: next edge gives count=0, pointers 0, overflow=0, empty=1, and no write.
6. Async reset mid-traffic:
   - Drop rst between clock edges at count=2: outputs return to reset values immediately, wr_en/rd_en = 0.
   - Release rst, push once: wr_addr 0 used, count becomes 1.
